// File: rtl/jtag_instruction_register.sv
// JTAG instruction register: a capture/shift stage (sr) feeding an update stage (Q),
// with a one-hot decode of the current instruction.
module jtag_instruction_register #(
  parameter int unsigned          IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]  IDCODE_OPC = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0]  SAMPLE_OPC = IR_WIDTH'(2),
  // Keeps the StatusIn port at least one bit wide when IR_WIDTH is 2
  parameter int unsigned          SW         = (IR_WIDTH > 2) ? IR_WIDTH - 2 : 1
) (
  input  logic                ClockIR,
  input  logic                Reset,
  input  logic                TDI,
  input  logic                CaptureIR,
  input  logic                ShiftIR,
  input  logic                UpdateIR,
  input  logic [SW-1:0]       StatusIn,
  output logic                TDO,
  output logic                TdoEn,
  output logic [IR_WIDTH-1:0] Q,
  output logic                BypassSel,
  output logic                IdcodeSel,
  output logic                ExtestSel,
  output logic                SampleSel
);

  localparam logic [IR_WIDTH-1:0] EXTEST_OPC = '0;
  localparam logic [IR_WIDTH-1:0] BYPASS_OPC = '1;
  localparam logic [IR_WIDTH-1:0] RESET_SR   = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0] sr;
  logic [IR_WIDTH-1:0] capture_val;

  generate
    if (IR_WIDTH > 2) begin : g_status
      assign capture_val = {StatusIn[IR_WIDTH-3:0], 2'b01};
    end else begin : g_no_status
      logic unused_status;
      assign unused_status = ^StatusIn;
      assign capture_val   = 2'b01;
    end
  endgenerate

  // Q samples the pre-edge sr, so an update alongside capture/shift sees the old value.
  always_ff @(posedge ClockIR) begin
    if (Reset) begin
      sr <= RESET_SR;
      Q  <= IDCODE_OPC;
    end else begin
      if (CaptureIR) begin
        sr <= capture_val;
      end else if (ShiftIR) begin
        sr <= {TDI, sr[IR_WIDTH-1:1]};
      end
      if (UpdateIR) begin
        Q <= sr;
      end
    end
  end

  assign TDO   = sr[0];
  assign TdoEn = ShiftIR;

  // Fixed opcodes outrank the parameterised ones; anything unrecognised is BYPASS.
  always_comb begin
    ExtestSel = 1'b0;
    IdcodeSel = 1'b0;
    SampleSel = 1'b0;
    BypassSel = 1'b0;
    if (Q == EXTEST_OPC) begin
      ExtestSel = 1'b1;
    end else if (Q == BYPASS_OPC) begin
      BypassSel = 1'b1;
    end else if (Q == IDCODE_OPC) begin
      IdcodeSel = 1'b1;
    end else if (Q == SAMPLE_OPC) begin
      SampleSel = 1'b1;
    end else begin
      BypassSel = 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_instruction_register.sv
// Bench for jtag_instruction_register: directed scenarios followed by random
// control sequences, all compared against a behavioural model of the IR.
module tb_jtag_instruction_register;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         tdi;
  logic         cap;
  logic         shf;
  logic         upd;
  logic [W-3:0] status;
  logic         tdo;
  logic         tdo_en;
  logic [W-1:0] q;
  logic         bypass_sel, idcode_sel, extest_sel, sample_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [W-1:0] m_sr;
  logic [W-1:0] m_q;

  logic [W-1:0] exp_q[$];

  jtag_instruction_register dut (
    .ClockIR   (clk),
    .Reset     (rst),
    .TDI       (tdi),
    .CaptureIR (cap),
    .ShiftIR   (shf),
    .UpdateIR  (upd),
    .StatusIn  (status),
    .TDO       (tdo),
    .TdoEn     (tdo_en),
    .Q         (q),
    .BypassSel (bypass_sel),
    .IdcodeSel (idcode_sel),
    .ExtestSel (extest_sel),
    .SampleSel (sample_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // expected selects as {bypass, idcode, extest, sample}
  function automatic logic [3:0] exp_sel(input logic [W-1:0] op);
    if (op == 4'b0000)      return 4'b0010;
    else if (op == 4'b1111) return 4'b1000;
    else if (op == 4'b0001) return 4'b0100;
    else if (op == 4'b0010) return 4'b0001;
    else                    return 4'b1000;
  endfunction

  // Apply current inputs for one edge, advance the model, compare all outputs.
  task automatic step();
    logic [W-1:0] pre_sr;
    pre_sr = m_sr;
    if (rst) begin
      m_sr = 4'b0001;
      m_q  = 4'b0001;
    end else begin
      if (upd) m_q = pre_sr;
      if (cap)      m_sr = {status, 2'b01};
      else if (shf) m_sr = (pre_sr >> 1) | (W'(tdi) << (W - 1));
    end
    @(posedge clk);
    #2;
    check("q", 32'(q), 32'(m_q));
    check("sr", 32'(dut.sr), 32'(m_sr));
    check("tdo", 32'(tdo), 32'(m_sr % 2));
    check("tdo_en", 32'(tdo_en), 32'(shf));
    check("sel", 32'({bypass_sel, idcode_sel, extest_sel, sample_sel}), 32'(exp_sel(m_q)));
  endtask

  task automatic drive(input logic r, input logic c, input logic s, input logic u, input logic d);
    rst = r; cap = c; shf = s; upd = u; tdi = d;
    step();
  endtask

  task automatic shift_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, w[i]);
  endtask

  initial begin
    rst = 1'b0; cap = 1'b0; shf = 1'b0; upd = 1'b0; tdi = 1'b0; status = 2'b00;
    m_sr = 'x; m_q = 'x;
    @(negedge clk);

    // reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_q", 32'(q), 32'h1);
    check("reset_idcode", 32'(idcode_sel), 32'h1);
    check("reset_tdo", 32'(tdo), 32'h1);

    // capture status then shift ones; TDO seen before each shift is 1,0,0,1
    status = 2'b10;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1);
    for (int i = 0; i < W; i++) begin
      check("tdo_seq", 32'(tdo), 32'(exp_q.pop_front()));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    check("sr_ones", 32'(dut.sr), 32'hf);
    check("q_held", 32'(q), 32'h1);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("upd_bypass_q", 32'(q), 32'hf);
    check("upd_bypass_sel", 32'(bypass_sel), 32'h1);
    check("upd_idcode_off", 32'(idcode_sel), 32'h0);

    // TDI 0,1,0,0 -> SAMPLE
    shift_word(4'b0010);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sample_q", 32'(q), 32'h2);
    check("sample_sel", 32'(sample_sel), 32'h1);
    shift_word(4'b0101);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("unknown_bypass", 32'(bypass_sel), 32'h1);

    // capture+shift+update together with sr cleared
    shift_word(4'b0000);
    status = 2'b11;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("triple_q", 32'(q), 32'h0);
    check("triple_extest", 32'(extest_sel), 32'h1);
    check("triple_sr", 32'(dut.sr), 32'hd);

    // reset mid-shift discards the partial word
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_sr", 32'(dut.sr), 32'h1);
    check("midrst_q", 32'(q), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("midrst_upd_q", 32'(q), 32'h1);

    // randomized control sequences
    for (int n = 0; n < 400; n++) begin
      status = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtag_instruction_register.md
JTAG_INSTRUCTION_REGISTER -- requirements
Module: jtag_instruction_register

Interface
REQ-001 Parameter IR_WIDTH, default 4: instruction length in bits, legal range 2..16.
REQ-002 Parameter IDCODE_OPC, default 4'b0001 (IR_WIDTH bits): IDCODE opcode, also the reset instruction.
REQ-003 Parameter SAMPLE_OPC, default 4'b0010 (IR_WIDTH bits): SAMPLE/PRELOAD opcode.
REQ-004 EXTEST opcode SHALL be fixed all-zeros; BYPASS opcode SHALL be fixed all-ones.
REQ-005 ClockIR  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 TDI  input  1  serial test data in.
REQ-008 CaptureIR  input  1  parallel-load enable for the shift stage.
REQ-009 ShiftIR  input  1  shift enable for the shift stage.
REQ-010 UpdateIR  input  1  transfer enable, shift stage to update stage.
REQ-011 StatusIn  input  IR_WIDTH-2  design status captured into the upper IR bits.
REQ-012 TDO  output  1  serial out, equal to shift-stage bit 0.
REQ-013 TdoEn  output  1  high while ShiftIR is high, otherwise low.
REQ-014 Q  output  IR_WIDTH  current (update-stage) instruction.
REQ-015 BypassSel, IdcodeSel, ExtestSel, SampleSel  output  1 each  one-hot decode of Q.

Function
REQ-016 Shift stage SR[IR_WIDTH-1:0] SHALL follow this priority each edge: Reset, then CaptureIR, then ShiftIR, then hold.
REQ-017 Capture SHALL load SR <= {StatusIn, 2'b01}.
REQ-018 Shift SHALL load SR <= {TDI, SR[IR_WIDTH-1:1]}: LSB-first out, first TDI bit reaches SR[0] after IR_WIDTH shifts.
REQ-019 CaptureIR and ShiftIR both high SHALL perform capture only.
REQ-020 Update stage Q SHALL load the pre-edge SR value when UpdateIR is high and Reset is low, and otherwise hold.
REQ-021 UpdateIR concurrent with ShiftIR or CaptureIR SHALL give Q the pre-edge SR, while SR performs its own operation.
REQ-022 Q SHALL change only on Reset or UpdateIR; shifting SHALL never disturb Q or the decode outputs.
REQ-023 Decode outputs SHALL be combinational from Q; exactly one select SHALL be high at all times.
REQ-024 Any opcode not EXTEST, IDCODE or SAMPLE SHALL assert BypassSel.
REQ-025 If IDCODE_OPC or SAMPLE_OPC collides with a fixed opcode, the fixed opcode's decode SHALL win.
REQ-026 TDO SHALL equal SR[0] combinationally, with zero latency from the SR update.
REQ-027 No counters or internal state SHALL exist beyond SR and Q (2*IR_WIDTH flops).

Reset
REQ-028 Reset high at an edge SHALL set SR <= {{(IR_WIDTH-2){1'b0}}, 2'b01} and Q <= IDCODE_OPC.
REQ-029 After that edge, IdcodeSel=1, the other selects=0, TDO=1 and TdoEn follows ShiftIR.
REQ-030 Reset SHALL override CaptureIR, ShiftIR and UpdateIR asserted in the same cycle.
REQ-031 Reset asserted mid-shift SHALL discard the partial shift.
REQ-032 Q contents before reset are undefined; the bench SHALL check only after the first reset.

Verification (IR_WIDTH=4, defaults)
REQ-033 Reset 1 cycle -> Q=4'b0001, IdcodeSel=1, TDO=1.
REQ-034 StatusIn=2'b10, CaptureIR 1 cycle, then ShiftIR 4 cycles with TDI=1,1,1,1 -> TDO sequence 1,0,0,1; SR=4'b1111; Q still 4'b0001.
REQ-035 UpdateIR 1 cycle after REQ-034 -> Q=4'b1111, BypassSel=1, IdcodeSel=0.
REQ-036 Shift TDI=0,1,0,0 then update -> Q=4'b0010, SampleSel=1; then shift 4'b0101 and update -> BypassSel=1.
REQ-037 CaptureIR=ShiftIR=UpdateIR=1 in one cycle with SR=4'b0000 -> Q=4'b0000, ExtestSel=1, SR={StatusIn,2'b01}.
REQ-038 Reset asserted after 2 of 4 shift cycles -> SR=4'b0001, Q=4'b0001; a following UpdateIR keeps Q=4'b0001.
